// File: rtl/lif_neuron_update_pipe_pkg.sv
// ----------------------------------------------------------------------------
// lif_pkg : shared types and helpers for the LIF neuron update pipeline
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package lif_pkg;

  typedef enum logic {LEAK_LIN = 1'b0, LEAK_SHIFT = 1'b1} leak_mode_e;
  typedef enum logic {RST_ZERO = 1'b0, RST_SUB = 1'b1} reset_mode_e;

  // Payload fields are sized for the widest supported configuration.
  localparam int c_IDX_MAX_W   = 32;
  localparam int c_STATE_MAX_W = 32;
  localparam int c_REFR_MAX_W  = 16;

  typedef struct packed {
    logic [c_IDX_MAX_W-1:0]   idx;
    logic [c_STATE_MAX_W-1:0] state;
    logic [c_REFR_MAX_W-1:0]  refr;
    logic                     spk_en;
  } lif_s1_t;

  // Signed saturation bound for a given width: upper=1 -> max, else min.
  function automatic logic signed [c_STATE_MAX_W:0] sat_limits(input int unsigned width,
                                                              input logic upper);
    logic signed [c_STATE_MAX_W:0] one;
    one    = '0;
    one[0] = 1'b1;
    if (upper) return (one <<< (width - 1)) - one;
    else       return -(one <<< (width - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/lif_neuron_update_pipe_if.sv
// ----------------------------------------------------------------------------
// lif_neuron_update_pipe_if : request/response handshake of the LIF pipeline
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface lif_neuron_update_pipe_if #(
  parameter int STATE_W  = 12,
  parameter int WEIGHT_W = 8,
  parameter int IDX_W    = 8,
  parameter int REFR_W   = 4
) ();

  logic                in_valid_i;
  logic                in_ready_o;
  logic [IDX_W-1:0]    in_idx_i;
  logic [STATE_W-1:0]  in_state_i;
  logic [REFR_W-1:0]   in_refr_i;
  logic [WEIGHT_W-1:0] in_weight_i;
  logic                in_time_ref_i;
  logic                out_valid_o;
  logic                out_ready_i;
  logic [IDX_W-1:0]    out_idx_o;
  logic [STATE_W-1:0]  out_state_o;
  logic [REFR_W-1:0]   out_refr_o;
  logic                out_spike_o;

  modport master (
    output in_valid_i, in_idx_i, in_state_i, in_refr_i, in_weight_i, in_time_ref_i,
    output out_ready_i,
    input  in_ready_o, out_valid_o, out_idx_o, out_state_o, out_refr_o, out_spike_o
  );

  modport slave (
    input  in_valid_i, in_idx_i, in_state_i, in_refr_i, in_weight_i, in_time_ref_i,
    input  out_ready_i,
    output in_ready_o, out_valid_o, out_idx_o, out_state_o, out_refr_o, out_spike_o
  );

endinterface

`default_nettype wire

// File: rtl/lif_neuron_update_pipe_sat_add.sv
// ----------------------------------------------------------------------------
// lif_sat_add : signed saturating add of a narrower operand onto a wider one
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lif_sat_add
  import lif_pkg::*;
#(
  parameter int A_W = 12,
  parameter int B_W = 8
) (
  input  logic signed [A_W-1:0] i_a,
  input  logic signed [B_W-1:0] i_b,
  output logic signed [A_W-1:0] o_sum
);

  localparam logic signed [A_W:0] c_MAX = (A_W+1)'(sat_limits(A_W, 1'b1));
  localparam logic signed [A_W:0] c_MIN = (A_W+1)'(sat_limits(A_W, 1'b0));

  logic signed [A_W:0] w_sum;

  assign w_sum = {i_a[A_W-1], i_a} + {{(A_W+1-B_W){i_b[B_W-1]}}, i_b};

  always_comb begin
    o_sum = w_sum[A_W-1:0];
    if (w_sum > c_MAX)      o_sum = c_MAX[A_W-1:0];
    else if (w_sum < c_MIN) o_sum = c_MIN[A_W-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/lif_neuron_update_pipe.sv
// ----------------------------------------------------------------------------
// lif_neuron_update_pipe : 2-stage LIF neuron update (leak/synapse, then spike)
// Optional LIF_REFRACTORY_EN adds refractory counting.  Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lif_neuron_update_pipe
  import lif_pkg::*;
#(
  parameter int STATE_W  = 12,
  parameter int WEIGHT_W = 8,
  parameter int LEAK_W   = 7,
  parameter int IDX_W    = 8,
  parameter int REFR_W   = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               param_enable_i,
  input  logic [LEAK_W-1:0]  param_leak_str_i,
  input  logic               param_leak_mode_i,
  input  logic               param_reset_mode_i,
  input  logic [STATE_W-2:0] param_thr_i,
  input  logic [REFR_W-1:0]  param_refr_i,
  lif_neuron_update_pipe_if.slave bus
);

  logic                      w_en;
  logic signed [STATE_W-1:0] w_syn_sum;
  logic                      w_neg;
  logic [STATE_W:0]          w_mag, w_mag_new, w_leak_amt;
  logic [31:0]               w_k;
  logic signed [STATE_W-1:0] w_leaked, w_state1;
  logic [REFR_W-1:0]         w_refr1;
  lif_s1_t                   w_s1, r_s1;
  logic                      r_s1_valid;

  logic [STATE_W-1:0]        w_s2_state, w_out_state;
  logic [REFR_W-1:0]         w_out_refr;
  logic                      w_spike;
  logic                      r_out_valid, r_out_spike;
  logic [IDX_W-1:0]          r_out_idx;
  logic [STATE_W-1:0]        r_out_state;
  logic [REFR_W-1:0]         r_out_refr;
  logic                      w_unused;

  // A single advance enable stalls both stages together.
  assign w_en           = ~r_out_valid | bus.out_ready_i;
  assign bus.in_ready_o = w_en;

  lif_sat_add #(.A_W(STATE_W), .B_W(WEIGHT_W)) u_sat_add (
    .i_a   (bus.in_state_i),
    .i_b   (bus.in_weight_i),
    .o_sum (w_syn_sum)
  );

  // Stage 1: leak works on the magnitude in STATE_W+1 bits so the most
  // negative state has a representable magnitude.
  always_comb begin
    w_neg      = bus.in_state_i[STATE_W-1];
    w_mag      = w_neg ? -{1'b1, bus.in_state_i} : {1'b0, bus.in_state_i};
    w_k        = 32'(param_leak_str_i);
    if (w_k > 32'(STATE_W-1)) w_k = 32'(STATE_W-1);
    w_leak_amt = (STATE_W+1)'(param_leak_str_i);
    if (leak_mode_e'(param_leak_mode_i) == LEAK_SHIFT) w_mag_new = w_mag - (w_mag >> w_k);
    else w_mag_new = (w_mag > w_leak_amt) ? w_mag - w_leak_amt : '0;
    w_leaked   = w_neg ? STATE_W'(-w_mag_new) : STATE_W'(w_mag_new);

    w_refr1    = '0;
    w_s1       = '0;
    w_s1.spk_en = 1'b1;
    if (bus.in_time_ref_i)  w_state1 = w_leaked;
    else if (!param_enable_i) w_state1 = w_syn_sum;
    else                    w_state1 = bus.in_state_i;
`ifdef LIF_REFRACTORY_EN
    if (bus.in_refr_i != '0) begin
      w_s1.spk_en = 1'b0;
      if (bus.in_time_ref_i) begin
        w_refr1 = bus.in_refr_i - REFR_W'(1);
      end else begin
        w_state1 = bus.in_state_i;
        w_refr1  = bus.in_refr_i;
      end
    end
`endif
    w_s1.idx   = c_IDX_MAX_W'(bus.in_idx_i);
    w_s1.state = c_STATE_MAX_W'(w_state1);
    w_s1.refr  = c_REFR_MAX_W'(w_refr1);
  end

  // Stage 2: threshold compare only matters for non-negative states.
  always_comb begin
    w_s2_state  = r_s1.state[STATE_W-1:0];
    w_spike     = r_s1.spk_en & ~w_s2_state[STATE_W-1] &
                  (w_s2_state[STATE_W-2:0] >= param_thr_i);
    w_out_state = w_s2_state;
    if (w_spike) begin
      if (reset_mode_e'(param_reset_mode_i) == RST_SUB)
        w_out_state = {1'b0, w_s2_state[STATE_W-2:0] - param_thr_i};
      else
        w_out_state = '0;
    end
`ifdef LIF_REFRACTORY_EN
    w_out_refr = w_spike ? param_refr_i : r_s1.refr[REFR_W-1:0];
`else
    w_out_refr = '0;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_valid  <= 1'b0;
      r_s1        <= '0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_state <= '0;
      r_out_refr  <= '0;
      r_out_spike <= 1'b0;
    end else if (w_en) begin
      r_s1_valid  <= bus.in_valid_i;
      r_s1        <= w_s1;
      r_out_valid <= r_s1_valid;
      r_out_idx   <= r_s1.idx[IDX_W-1:0];
      r_out_state <= w_out_state;
      r_out_refr  <= w_out_refr;
      r_out_spike <= w_spike;
    end
  end

  assign bus.out_valid_o = r_out_valid;
  assign bus.out_idx_o   = r_out_idx;
  assign bus.out_state_o = r_out_state;
  assign bus.out_refr_o  = r_out_refr;
  assign bus.out_spike_o = r_out_spike;

  // Upper payload bits and build-dependent refractory inputs are intentionally dead.
  assign w_unused = ^{r_s1, bus.in_refr_i, param_refr_i};

endmodule

`default_nettype wire

// File: tb/tb_lif_neuron_update_pipe.sv
// ----------------------------------------------------------------------------
// tb_lif_neuron_update_pipe : scoreboard bench with directed and random traffic
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_lif_neuron_update_pipe;
  import lif_pkg::*;

  localparam int STATE_W  = 12;
  localparam int WEIGHT_W = 8;
  localparam int LEAK_W   = 7;
  localparam int IDX_W    = 8;
  localparam int REFR_W   = 4;
  localparam int S_MAX    = 2047;
  localparam int S_MIN    = -2048;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  logic               param_enable_i     = 1'b0;
  logic [LEAK_W-1:0]  param_leak_str_i   = '0;
  logic               param_leak_mode_i  = 1'b0;
  logic               param_reset_mode_i = 1'b0;
  logic [STATE_W-2:0] param_thr_i        = '0;
  logic [REFR_W-1:0]  param_refr_i       = '0;

  always #5 clk_i = ~clk_i;

  lif_neuron_update_pipe_if #(.STATE_W(STATE_W), .WEIGHT_W(WEIGHT_W),
                              .IDX_W(IDX_W), .REFR_W(REFR_W)) bus ();

  lif_neuron_update_pipe #(.STATE_W(STATE_W), .WEIGHT_W(WEIGHT_W), .LEAK_W(LEAK_W),
                           .IDX_W(IDX_W), .REFR_W(REFR_W)) dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .param_enable_i     (param_enable_i),
    .param_leak_str_i   (param_leak_str_i),
    .param_leak_mode_i  (param_leak_mode_i),
    .param_reset_mode_i (param_reset_mode_i),
    .param_thr_i        (param_thr_i),
    .param_refr_i       (param_refr_i),
    .bus                (bus)
  );

  typedef struct { int idx; int state; int refr; int weight; bit tref; } req_t;
  typedef struct { int idx; int state; int refr; bit spike; } exp_t;

  req_t req_q[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   idx_ctr = 0;
  bit   gap_rand = 1'b0;
  int   out_ready_pct = 100;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: neuron rules applied with plain integer arithmetic.
  function automatic exp_t model(req_t r);
    exp_t e;
    int   s = r.state;
    int   lk = int'(param_leak_str_i);
    int   thr = int'(param_thr_i);
    int   refr = 0;
    bit   can_spike = 1'b1;
`ifdef LIF_REFRACTORY_EN
    if (r.refr != 0) begin
      can_spike = 1'b0;
      refr = r.tref ? r.refr - 1 : r.refr;
    end
`endif
    if (r.tref) begin
      if (param_leak_mode_i == 1'b0) begin
        if (s >= 0) s = (s > lk) ? s - lk : 0;
        else        s = (-s > lk) ? s + lk : 0;
      end else begin
        int k = (lk > STATE_W - 1) ? STATE_W - 1 : lk;
        int m = (s < 0) ? -s : s;
        m = m - (m >> k);
        s = (s < 0) ? -m : m;
      end
    end else if (!param_enable_i && can_spike) begin
      s = s + r.weight;
      if (s > S_MAX) s = S_MAX;
      if (s < S_MIN) s = S_MIN;
    end
    e.spike = can_spike && (s >= 0) && (s >= thr);
    if (e.spike) begin
      s = param_reset_mode_i ? s - thr : 0;
`ifdef LIF_REFRACTORY_EN
      refr = int'(param_refr_i);
`endif
    end
    e.idx = r.idx;
    e.state = s;
    e.refr = refr;
    return e;
  endfunction

  task automatic push_req(int state, int weight, bit tref, int refr);
    req_t r;
    r.idx = idx_ctr % 256;
    idx_ctr++;
    r.state = state;
    r.weight = weight;
    r.tref = tref;
    r.refr = refr;
    req_q.push_back(r);
  endtask

  task automatic set_params(bit en, int lk, bit lmode, bit rmode, int thr, int refr);
    @(negedge clk_i);
    param_enable_i     = en;
    param_leak_str_i   = LEAK_W'(lk);
    param_leak_mode_i  = lmode;
    param_reset_mode_i = rmode;
    param_thr_i        = (STATE_W-1)'(thr);
    param_refr_i       = REFR_W'(refr);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (req_q.size() != 0 || exp_q.size() != 0); i++)
      @(negedge clk_i);
    check("drain_pending", req_q.size() + exp_q.size(), 0);
  endtask

  // Driver: inputs change on the falling edge, acceptance is judged just before the rising edge.
  initial begin
    bus.in_valid_i = 1'b0;
    bus.in_idx_i = '0;
    bus.in_state_i = '0;
    bus.in_refr_i = '0;
    bus.in_weight_i = '0;
    bus.in_time_ref_i = 1'b0;
    bus.out_ready_i = 1'b1;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        bus.in_valid_i = 1'b0;
      end else begin
        if (req_q.size() != 0 && !(gap_rand && $urandom_range(0, 3) == 0)) begin
          bus.in_valid_i    = 1'b1;
          bus.in_idx_i      = IDX_W'(req_q[0].idx);
          bus.in_state_i    = STATE_W'(req_q[0].state);
          bus.in_weight_i   = WEIGHT_W'(req_q[0].weight);
          bus.in_refr_i     = REFR_W'(req_q[0].refr);
          bus.in_time_ref_i = req_q[0].tref;
        end else begin
          bus.in_valid_i = 1'b0;
        end
        bus.out_ready_i = (out_ready_pct >= 100) ? 1'b1 :
                          (int'($urandom_range(0, 99)) < out_ready_pct);
      end
      #4;
      if (rst_ni && bus.in_valid_i && bus.in_ready_o)
        exp_q.push_back(model(req_q.pop_front()));
    end
  end

  // Monitor: every valid cycle must show the scoreboard head; pop on transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      #4;
      if (rst_ni) begin
        check("in_ready", int'(bus.in_ready_o), int'(!bus.out_valid_o || bus.out_ready_i));
        if (bus.out_valid_o) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output_idx", int'(bus.out_idx_o), -1);
          end else begin
            e = exp_q[0];
            check("out_idx", int'(bus.out_idx_o), e.idx);
            check("out_state", int'($signed(bus.out_state_o)), e.state);
            check("out_spike", int'(bus.out_spike_o), int'(e.spike));
            check("out_refr", int'(bus.out_refr_o), e.refr);
            if (bus.out_ready_i) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_out_valid", int'(bus.out_valid_o), 0);
    check("rst_out_state", int'(bus.out_state_o), 0);
    check("rst_out_idx", int'(bus.out_idx_o), 0);
    check("rst_out_spike", int'(bus.out_spike_o), 0);
    check("rst_out_refr", int'(bus.out_refr_o), 0);
    check("rst_in_ready", int'(bus.in_ready_o), 1);
    rst_ni = 1'b1;

    // Positive saturation into a spike, then a refractory follow-up.
    set_params(1'b0, 0, 1'b0, 1'b0, 2047, 3);
    push_req(2032, 127, 1'b0, 0);
    push_req(5, 10, 1'b0, 3);
    drain();
    // Negative saturation.
    push_req(-2047, -128, 1'b0, 0);
    drain();
    // Linear leak by 7.
    set_params(1'b0, 7, 1'b0, 1'b0, 2047, 0);
    push_req(5, 0, 1'b1, 0);
    push_req(-3, 0, 1'b1, 0);
    push_req(256, 0, 1'b1, 0);
    drain();
    // Shift leak with k=2, then k clamped from 20.
    set_params(1'b0, 2, 1'b1, 1'b0, 2047, 0);
    push_req(256, 0, 1'b1, 0);
    push_req(-256, 0, 1'b1, 0);
    drain();
    set_params(1'b0, 20, 1'b1, 1'b0, 2047, 0);
    push_req(256, 0, 1'b1, 0);
    push_req(-2048, 0, 1'b1, 0);
    drain();
    // Subtract-threshold reset, then the same request with the neuron disabled.
    set_params(1'b0, 0, 1'b0, 1'b1, 100, 0);
    push_req(90, 20, 1'b0, 0);
    drain();
    set_params(1'b1, 0, 1'b0, 1'b1, 100, 0);
    push_req(90, 20, 1'b0, 0);
    push_req(0, 5, 1'b0, 0);
    drain();

    // Back-pressure: three requests against a stalled output.
    set_params(1'b0, 3, 1'b0, 1'b0, 1500, 0);
    out_ready_pct = 0;
    push_req(100, 50, 1'b0, 0);
    push_req(-100, -50, 1'b0, 0);
    push_req(300, 0, 1'b1, 0);
    repeat (6) @(negedge clk_i);
    #2;
    check("stall_out_valid", int'(bus.out_valid_o), 1);
    check("stall_in_ready", int'(bus.in_ready_o), 0);
    check("stall_pending_reqs", req_q.size(), 1);
    out_ready_pct = 100;
    drain();

    // Asynchronous reset during a stall drops in-flight work immediately.
    out_ready_pct = 0;
    push_req(10, 1, 1'b0, 0);
    push_req(20, 2, 1'b0, 0);
    repeat (5) @(negedge clk_i);
    #2;
    check("prerst_out_valid", int'(bus.out_valid_o), 1);
    rst_ni = 1'b0;
    #1;
    check("midrst_out_valid", int'(bus.out_valid_o), 0);
    check("midrst_out_state", int'(bus.out_state_o), 0);
    req_q.delete();
    exp_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    out_ready_pct = 100;

    // Randomised traffic with gaps and random back-pressure.
    gap_rand = 1'b1;
    out_ready_pct = 70;
    for (int b = 0; b < 20; b++) begin
      set_params($urandom_range(0, 3) == 0, int'($urandom_range(0, 127)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 2047)), int'($urandom_range(0, 15)));
      for (int i = 0; i < 30; i++)
        push_req(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 255)) - 128,
                 $urandom_range(0, 2) == 0,
                 ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 15)));
      drain();
    end

    repeat (3) @(negedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
